// File: rtl/farbdma_pkg.sv
// farbdma_pkg: shared constants for the Farbborg DMA engine.
// Register map, control/status bits, FSM states, lane selects.
package farbdma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_IRQEN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  localparam logic [3:0] SEL_WORD = 4'hF;
  localparam logic [3:0] SEL_BYTE = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP
  } state_t;

endpackage

// File: rtl/wb_farbdma_regs.sv
// wb_farbdma_regs: slave decode, ack and register file.
// FARBDMA_IRQ_EN adds the CTRL.IRQ_EN bit.
module wb_farbdma_regs
  import farbdma_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       i_adr,
  input  logic [31:0]      i_dat,
  output logic [31:0]      o_dat,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  output logic             o_ack,
  input  logic             i_busy,
  input  logic             i_done,
  output logic [29:0]      o_src,
  output logic [LEN_W-1:0] o_len,
  output logic             o_loop,
  output logic             o_start,
  output logic             o_stop,
  output logic             o_done_clr
`ifdef FARBDMA_IRQ_EN
  ,output logic            o_irq_en
`endif
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [29:0]      r_src;
  logic [LEN_W-1:0] r_len;
  logic             r_loop;
  logic             r_start;
  logic             r_stop;
  logic             r_done_clr;
  logic             w_req;
  logic [31:0]      w_rdata;
  logic [1:0]       w_unused;
`ifdef FARBDMA_IRQ_EN
  logic             r_irq_en;
  assign o_irq_en = r_irq_en;
`endif

  assign w_unused   = i_adr[1:0];
  assign w_req      = i_cyc & i_stb & ~r_ack;
  assign o_ack      = r_ack;
  assign o_dat      = r_dat;
  assign o_src      = r_src;
  assign o_len      = r_len;
  assign o_loop     = r_loop;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_done_clr = r_done_clr;

  // Read mux for the addressed register
  always_comb begin
    w_rdata = '0;
    unique case (i_adr[3:2])
      REG_SRC:  w_rdata = {r_src, 2'b00};
      REG_LEN:  w_rdata[LEN_W-1:0] = r_len;
      REG_CTRL: begin
        w_rdata[CTRL_LOOP] = r_loop;
`ifdef FARBDMA_IRQ_EN
        w_rdata[CTRL_IRQEN] = r_irq_en;
`endif
      end
      REG_STAT: begin
        w_rdata[STAT_BUSY] = i_busy;
        w_rdata[STAT_DONE] = i_done;
      end
    endcase
  end

  // Single-cycle ack; writes and command pulses land with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_src      <= '0;
      r_len      <= '0;
      r_loop     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_done_clr <= 1'b0;
`ifdef FARBDMA_IRQ_EN
      r_irq_en   <= 1'b0;
`endif
    end else begin
      r_ack      <= w_req;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_done_clr <= 1'b0;
      if (w_req) begin
        r_dat <= w_rdata;
        if (i_we) begin
          unique case (i_adr[3:2])
            REG_SRC:  r_src <= i_dat[31:2];
            REG_LEN:  r_len <= i_dat[LEN_W-1:0];
            REG_CTRL: begin
              r_start  <= i_dat[CTRL_START];
              r_loop   <= i_dat[CTRL_LOOP];
              r_stop   <= i_dat[CTRL_STOP];
`ifdef FARBDMA_IRQ_EN
              r_irq_en <= i_dat[CTRL_IRQEN];
`endif
            end
            REG_STAT: r_done_clr <= i_dat[STAT_DONE];
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/wb_farbdma.sv
// wb_farbdma: Wishbone DMA from memory words into Farbborg bytes.
// FARBDMA_IRQ_EN adds irq_o = DONE & IRQ_EN.
module wb_farbdma
  import farbdma_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'hF000_0000,
  parameter int          LEN_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
`ifdef FARBDMA_IRQ_EN
  ,output logic       irq_o
`endif
);

  state_t           r_state;
  logic [29:0]      r_src_l;
  logic [29:0]      r_adr;
  logic [LEN_W-1:0] r_len_l;
  logic [LEN_W-1:0] r_left;
  logic [1:0]       r_byte;
  logic [10:0]      r_fbi;
  logic [31:0]      r_data;
  logic             r_done;
  logic             r_stop_pend;
  logic             r_stb;
  logic [29:0]      w_src;
  logic [LEN_W-1:0] w_len;
  logic             w_loop;
  logic             w_start;
  logic             w_stop;
  logic             w_done_clr;
  logic             w_busy;
  logic             w_stop_now;
  logic [31:0]      w_fb_adr;
  logic [3:0]       w_unused;

  assign w_unused   = wb_sel_i;
  assign w_busy     = (r_state != S_IDLE);
  assign w_stop_now = r_stop_pend | w_stop;
  assign w_fb_adr   = FB_BASE + {19'd0, r_fbi, 2'b00};
  assign m_cyc_o    = r_stb;
  assign m_stb_o    = r_stb;

`ifdef FARBDMA_IRQ_EN
  logic w_irq_en;
  assign irq_o = r_done & w_irq_en;
`endif

  wb_farbdma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .i_adr      (wb_adr_i),
    .i_dat      (wb_dat_i),
    .o_dat      (wb_dat_o),
    .i_cyc      (wb_cyc_i),
    .i_stb      (wb_stb_i),
    .i_we       (wb_we_i),
    .o_ack      (wb_ack_o),
    .i_busy     (w_busy),
    .i_done     (r_done),
    .o_src      (w_src),
    .o_len      (w_len),
    .o_loop     (w_loop),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_done_clr (w_done_clr)
`ifdef FARBDMA_IRQ_EN
    ,.o_irq_en  (w_irq_en)
`endif
  );

  // Transfer FSM with registered master outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_src_l     <= '0;
      r_adr       <= '0;
      r_len_l     <= '0;
      r_left      <= '0;
      r_byte      <= '0;
      r_fbi       <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_stb       <= 1'b0;
      m_we_o      <= 1'b0;
      m_sel_o     <= '0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
    end else begin
      if (w_done_clr) r_done <= 1'b0;
      if (w_stop && w_busy) r_stop_pend <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (w_start && w_len == '0) begin
            r_done <= 1'b1;
          end else if (w_start) begin
            r_src_l <= w_src;
            r_len_l <= w_len;
            r_adr   <= w_src;
            r_left  <= w_len;
            r_fbi   <= '0;
            r_done  <= 1'b0;
            r_state <= S_RD;
            r_stb   <= 1'b1;
            m_we_o  <= 1'b0;
            m_sel_o <= SEL_WORD;
            m_adr_o <= {w_src, 2'b00};
          end
        end
        S_RD: begin
          if (m_ack_i) begin
            if (w_stop_now) begin
              r_state     <= S_IDLE;
              r_stop_pend <= 1'b0;
              r_stb       <= 1'b0;
              m_sel_o     <= '0;
              m_adr_o     <= '0;
            end else begin
              r_data  <= m_dat_i;
              r_byte  <= 2'd0;
              r_state <= S_WR;
              m_we_o  <= 1'b1;
              m_sel_o <= SEL_BYTE;
              m_adr_o <= w_fb_adr;
              m_dat_o <= {24'h0, m_dat_i[31:24]};
            end
          end
        end
        S_WR: begin
          if (m_ack_i) begin
            r_fbi   <= r_fbi + 11'd1;
            r_byte  <= r_byte + 2'd1;
            r_data  <= r_data << 8;
            r_state <= S_GAP;
            r_stb   <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            m_adr_o <= '0;
            m_dat_o <= '0;
          end
        end
        S_GAP: begin
          if (r_byte != 2'd0 && !w_stop_now) begin
            r_state <= S_WR;
            r_stb   <= 1'b1;
            m_we_o  <= 1'b1;
            m_sel_o <= SEL_BYTE;
            m_adr_o <= w_fb_adr;
            m_dat_o <= {24'h0, r_data[31:24]};
          end else if (r_byte == 2'd0 && r_left != LEN_W'(1)
                       && !w_stop_now) begin
            r_left  <= r_left - LEN_W'(1);
            r_adr   <= r_adr + 30'd1;
            r_state <= S_RD;
            r_stb   <= 1'b1;
            m_sel_o <= SEL_WORD;
            m_adr_o <= {r_adr + 30'd1, 2'b00};
          end else if (r_byte == 2'd0 && r_left == LEN_W'(1)
                       && w_loop && !w_stop_now) begin
            r_done  <= 1'b1;
            r_adr   <= r_src_l;
            r_left  <= r_len_l;
            r_fbi   <= '0;
            r_state <= S_RD;
            r_stb   <= 1'b1;
            m_sel_o <= SEL_WORD;
            m_adr_o <= {r_src_l, 2'b00};
          end else begin
            if (r_byte == 2'd0 && r_left == LEN_W'(1)) r_done <= 1'b1;
            r_state     <= S_IDLE;
            r_stop_pend <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_farbdma.sv
// tb_wb_farbdma: random transfers against a queue-based model.
// Memory and Farbborg both ack on the second strobe cycle.
`timescale 1ns/1ps
module tb_wb_farbdma;

  localparam logic [31:0] FB = 32'hF000_0000;
  localparam logic [3:0] A_SRC  = 4'h0;
  localparam logic [3:0] A_LEN  = 4'h4;
  localparam logic [3:0] A_CTRL = 4'h8;
  localparam logic [3:0] A_STAT = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
`ifdef FARBDMA_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_farbdma dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
`ifdef FARBDMA_IRQ_EN
    ,.irq_o(irq_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image: a fixed word at 0x100, hash elsewhere
  logic [31:0] seed;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hA1B2C3D4;
    return (a * 32'h0100_0193) ^ seed ^ (a >> 7);
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        wq[$];
  txn_t        ew[$];
  logic [31:0] rq[$];
  logic [31:0] er[$];
  int cyc_n = 0;
  int first_stb = -1;
  int last_wack = -1;
  int bad_drop = 0;
  int bad_sel = 0;
  int stb_cnt = 0;

  // Bus responder: acks every strobe on its second cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ack_i <= 1'b0;
      m_dat_i <= '0;
    end else begin
      cyc_n++;
      m_ack_i <= 1'b0;
      if (m_ack_i && !(m_cyc_o && m_stb_o)) bad_drop++;
      if (m_ack_i && m_we_o) last_wack = cyc_n;
      if (m_cyc_o && m_stb_o && !m_ack_i) begin
        m_ack_i <= 1'b1;
        stb_cnt++;
        if (first_stb < 0) first_stb = cyc_n;
        if (m_we_o) begin
          if (m_sel_o != 4'b0001) bad_sel++;
          wq.push_back('{m_adr_o, m_dat_o});
        end else begin
          if (m_sel_o != 4'hF) bad_sel++;
          rq.push_back(m_adr_o);
          m_dat_i <= mem_word(m_adr_o);
        end
      end
    end
  end

  task automatic wb_xfer(input logic [3:0] a, input logic we,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    n = 0;
    @(negedge clk);
    wb_adr_i = a; wb_we_i = we; wb_dat_i = d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 20);
    chk("wb_ack_lat", 32'(n), 32'd1);
    q = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, 1'b1, d, q);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
    wb_xfer(a, 1'b0, 32'h0, q);
  endtask

  task automatic wait_idle(input int maxp);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      wb_read(A_STAT, s);
      n++;
    end while (s[0] && n < maxp);
    chk("busy_timeout", {31'd0, s[0]}, 32'd0);
  endtask

  task automatic clear_logs();
    wq.delete(); rq.delete(); ew.delete(); er.delete();
    first_stb = -1;
    last_wack = -1;
  endtask

  // Reference: word i byte b lands at FB + 4*(4i+b) mod 8192
  task automatic add_words(input logic [31:0] src, input int len);
    logic [31:0] w, a;
    int k;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      w = mem_word(a);
      er.push_back(a);
      for (int b = 0; b < 4; b++) begin
        k = ((4 * i + b) * 4) % 8192;
        ew.push_back('{FB + 32'(k), (w >> (24 - 8 * b)) & 32'hFF});
      end
    end
  endtask

  task automatic cmp(input string tag, input bit exact);
    if (exact) begin
      chk({tag, "_nwr"}, 32'(wq.size()), 32'(ew.size()));
      chk({tag, "_nrd"}, 32'(rq.size()), 32'(er.size()));
    end else begin
      chk({tag, "_nwr_le"}, 32'(wq.size() <= ew.size()), 32'd1);
    end
    for (int i = 0; i < wq.size() && i < ew.size(); i++) begin
      chk({tag, "_wadr"}, wq[i].a, ew[i].a);
      chk({tag, "_wdat"}, wq[i].d, ew[i].d);
    end
    for (int i = 0; i < rq.size() && i < er.size(); i++)
      chk({tag, "_radr"}, rq[i], er[i]);
    chk({tag, "_drop"}, 32'(bad_drop), 32'd0);
    chk({tag, "_sel"}, 32'(bad_sel), 32'd0);
  endtask

  initial begin
    logic [31:0] q, src;
    int n, len, rec;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    seed = $urandom;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    chk("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
    chk("rst_m_we", {31'd0, m_we_o}, 32'd0);
    chk("rst_m_adr", m_adr_o, 32'd0);
    chk("rst_m_dat", m_dat_o, 32'd0);
    chk("rst_m_sel", {28'd0, m_sel_o}, 32'd0);
    chk("rst_wb_ack", {31'd0, wb_ack_o}, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wb_read(4'(4 * r), q);
      chk("rst_reg", q, 32'd0);
    end

    // Single word, big-endian byte order
    clear_logs();
    wb_write(A_SRC, 32'h100);
    wb_write(A_LEN, 32'd1);
    wb_write(A_CTRL, 32'd1);
    wb_read(A_STAT, q);
    chk("t1_busy", q, 32'd1);
    wait_idle(200);
    wb_read(A_STAT, q);
    chk("t1_status", q, 32'd2);
    ew.push_back('{FB + 32'h0, 32'hA1});
    ew.push_back('{FB + 32'h4, 32'hB2});
    ew.push_back('{FB + 32'h8, 32'hC3});
    ew.push_back('{FB + 32'hC, 32'hD4});
    er.push_back(32'h100);
    cmp("t1", 1'b1);
    chk("t1_cycles", 32'(last_wack - first_stb), 32'd12);

    // LEN=0: DONE without bus traffic
    wb_write(A_STAT, 32'd2);
    wb_read(A_STAT, q);
    chk("w1c_done", q, 32'd0);
    wb_write(A_LEN, 32'd0);
    rec = stb_cnt;
    wb_write(A_CTRL, 32'd1);
    wb_read(A_STAT, q);
    chk("len0_status", q, 32'd2);
    repeat (20) @(negedge clk);
    chk("len0_no_stb", 32'(stb_cnt), 32'(rec));

    // Full Farbborg image
    clear_logs();
    seed = $urandom;
    add_words(32'h0, 512);
    wb_write(A_SRC, 32'h0);
    wb_write(A_LEN, 32'd512);
    wb_write(A_CTRL, 32'd1);
    wb_read(A_STAT, q);
    chk("t512_busy_done_clr", q, 32'd1);
    wait_idle(6000);
    cmp("t512", 1'b1);
    chk("t512_last", wq.size() > 0 ? wq[wq.size()-1].a : 32'h0,
        FB + 32'h1FFC);
    chk("t512_cycles", 32'(last_wack - first_stb), 32'(14 * 512 - 2));

    // Random transfers
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      seed = $urandom;
      len = $urandom_range(1, 24);
      src = $urandom & 32'h000F_FFFC;
      add_words(src, len);
      wb_write(A_SRC, src | 32'($urandom_range(0, 3)));
      wb_read(A_SRC, q);
      chk("rnd_src_rb", q, src);
      wb_write(A_LEN, 32'(len));
      wb_read(A_LEN, q);
      chk("rnd_len_rb", q, 32'(len));
      wb_write(A_CTRL, 32'd1);
      wait_idle(500);
      cmp("rnd", 1'b1);
      chk("rnd_cycles", 32'(last_wack - first_stb), 32'(14 * len - 2));
    end

    // FB offset wraps past 8 KiB
    clear_logs();
    src = $urandom & 32'h000F_FFFC;
    add_words(src, 520);
    wb_write(A_SRC, src);
    wb_write(A_LEN, 32'd520);
    wb_write(A_CTRL, 32'd1);
    wait_idle(6000);
    cmp("wrap", 1'b1);

    // START and LEN/SRC rewrite while busy
    clear_logs();
    src = $urandom & 32'h000F_FFFC;
    add_words(src, 8);
    wb_write(A_SRC, src);
    wb_write(A_LEN, 32'd8);
    wb_write(A_CTRL, 32'd1);
    wb_write(A_LEN, 32'd3);
    wb_write(A_SRC, src + 32'h400);
    wb_write(A_CTRL, 32'd1);
    wait_idle(500);
    cmp("busy_start", 1'b1);
    wb_read(A_LEN, q);
    chk("busy_len_rb", q, 32'd3);
    clear_logs();
    add_words(src + 32'h400, 3);
    wb_write(A_CTRL, 32'd1);
    wait_idle(500);
    cmp("next_start", 1'b1);

    // CTRL readback: START/STOP read 0, IRQ_EN only when built in
    wb_write(A_CTRL, 32'hA);
    wb_read(A_CTRL, q);
`ifdef FARBDMA_IRQ_EN
    chk("ctrl_rb", q, 32'hA);
`else
    chk("ctrl_rb", q, 32'h2);
`endif
    wb_write(A_CTRL, 32'h0);

    // LOOP re-reads SRC; STOP mid-write ends cleanly
    clear_logs();
    src = $urandom & 32'h000F_FFFC;
    for (int p = 0; p < 4; p++) add_words(src, 2);
    wb_write(A_SRC, src);
    wb_write(A_LEN, 32'd2);
    wb_write(A_CTRL, 32'h3);
    n = 0;
    while (rq.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("loop_wait_rd", 32'(n < 2000), 32'd1);
    chk("loop_reread", rq.size() > 2 ? rq[2] : 32'h0, src);
    n = 0;
    while (!(m_stb_o && m_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("loop_wait_wr", 32'(n < 100), 32'd1);
    wb_write(A_CTRL, 32'h6);
    wait_idle(100);
    wb_read(A_STAT, q);
    chk("stop_status", q, 32'd2);
    chk("loop_nwr_ge", 32'(wq.size() >= 8), 32'd1);
    cmp("loop", 1'b0);
    rec = stb_cnt;
    repeat (60) @(negedge clk);
    chk("stop_no_stb", 32'(stb_cnt), 32'(rec));
    wb_write(A_CTRL, 32'h0);

`ifdef FARBDMA_IRQ_EN
    // Level interrupt follows DONE & IRQ_EN
    wb_write(A_STAT, 32'd2);
    chk("irq_low", {31'd0, irq_o}, 32'd0);
    wb_write(A_SRC, 32'h100);
    wb_write(A_LEN, 32'd1);
    wb_write(A_CTRL, 32'h9);
    wait_idle(200);
    chk("irq_high", {31'd0, irq_o}, 32'd1);
    wb_write(A_STAT, 32'd2);
    @(negedge clk);
    chk("irq_w1c", {31'd0, irq_o}, 32'd0);
`endif

    // Reset in the middle of a write cycle
    clear_logs();
    wb_write(A_SRC, 32'h200);
    wb_write(A_LEN, 32'd4);
    wb_write(A_CTRL, 32'h3);
    n = 0;
    while (!(m_stb_o && m_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_wr", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_cyc", {31'd0, m_cyc_o}, 32'd0);
    chk("rst_mid_stb", {31'd0, m_stb_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rec = stb_cnt;
    for (int r = 0; r < 4; r++) begin
      wb_read(4'(4 * r), q);
      chk("rst_mid_reg", q, 32'd0);
    end
    repeat (30) @(negedge clk);
    chk("rst_mid_no_stb", 32'(stb_cnt), 32'(rec));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
